// File: rtl/clock_ctrl_if.sv
// Control/status bundle between the register logic and clock_ctrl.
// CLK_CTRL_BURST_EN adds the burst length input and the burst-done pulse.
interface clock_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             i_start;
   logic             i_stop;
   logic [WIDTH-1:0] i_div;
   logic             i_div_valid;
   logic             o_div_ready;
   logic             o_roll_over;
   logic             o_clk;
   logic             o_running;
`ifdef CLK_CTRL_BURST_EN
   logic [WIDTH-1:0] i_burst_len;
   logic             o_done;
`endif

   modport slave (
      input  i_start, i_stop, i_div, i_div_valid,
`ifdef CLK_CTRL_BURST_EN
      input  i_burst_len,
      output o_done,
`endif
      output o_div_ready, o_roll_over, o_clk, o_running
   );

   modport master (
      output i_start, i_stop, i_div, i_div_valid,
`ifdef CLK_CTRL_BURST_EN
      output i_burst_len,
      input  o_done,
`endif
      input  o_div_ready, o_roll_over, o_clk, o_running
   );
endinterface

// File: rtl/clock_ctrl.sv
// Divided-clock sequencer: rollover pulse every div_eff cycles, parked-high o_clk.
// Optional burst mode (fixed number of output periods) under CLK_CTRL_BURST_EN.
module clock_ctrl #(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   clock_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_STOPPING = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_div_active;
   logic [WIDTH-1:0] r_div_pend;
   logic             r_pend_valid;
   logic             r_clk;
   logic             r_roll;
   logic             r_running;
   logic             r_div_ready;

   logic [WIDTH-1:0] w_div_eff;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_div_nxt;
   logic             w_wrap;
   logic             w_park;
   logic             w_roll;
   logic             w_rise;
   logic             w_accept;
   logic             w_accept_run;
   logic             w_apply;
   logic             w_ready_nxt;
   logic             w_burst_last;

   function automatic logic [WIDTH-1:0] f_div_eff(input logic [WIDTH-1:0] d);
      return (d == '0) ? WIDTH'(1) : d;
   endfunction

   assign w_div_eff = f_div_eff(r_div_active);
   assign w_wrap    = (r_cnt == (w_div_eff - WIDTH'(1)));
   // Stopping during the high phase just parks: the high phase stretches, no edge.
   assign w_park    = (r_state == S_RUN) && bus.i_stop && r_clk;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.i_start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            // A stop landing on the rising rollover is already parked after that edge.
            if (bus.i_stop) begin
               if (r_clk || w_wrap) w_state_nxt = S_IDLE;
               else                 w_state_nxt = S_STOPPING;
            end else if (w_rise && w_burst_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_STOPPING: begin
            if (w_wrap) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_roll       = (r_state != S_IDLE) && w_wrap && !w_park;
      w_rise       = w_roll && !r_clk;
      w_accept     = bus.i_div_valid && r_div_ready;
      w_accept_run = w_accept && (r_state != S_IDLE);
      w_apply      = r_pend_valid && (w_roll || w_park);
      w_ready_nxt  = !(r_pend_valid || w_accept_run);

      w_cnt_nxt = r_cnt + WIDTH'(1);
      if ((r_state == S_IDLE) || w_roll || w_park) w_cnt_nxt = '0;

      w_div_nxt = r_div_active;
      if ((r_state == S_IDLE) && w_accept) w_div_nxt = bus.i_div;
      else if (w_apply)                    w_div_nxt = r_div_pend;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt        <= '0;
         r_div_active <= WIDTH'(DEFAULT_DIV);
         r_pend_valid <= 1'b0;
         r_clk        <= 1'b1;
         r_roll       <= 1'b0;
         r_running    <= 1'b0;
         r_div_ready  <= 1'b1;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_div_active <= w_div_nxt;
         r_clk        <= w_roll ? !r_clk : r_clk;
         r_roll       <= w_roll;
         r_running    <= (w_state_nxt != S_IDLE);
         r_div_ready  <= w_ready_nxt;
         if (w_accept_run) r_pend_valid <= 1'b1;
         else if (w_apply) r_pend_valid <= 1'b0;
      end
   end

   // Pending data only matters while r_pend_valid is set, so it carries no reset.
   always_ff @(posedge i_clk) begin
      if (w_accept_run) r_div_pend <= bus.i_div;
   end

`ifdef CLK_CTRL_BURST_EN
   logic [WIDTH-1:0] r_burst_cnt;
   logic             r_done;
   logic             w_done;

   assign w_burst_last = (r_burst_cnt == WIDTH'(1));
   assign w_done       = (r_state == S_RUN) && !bus.i_stop && w_rise && w_burst_last;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_burst_cnt <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_done;
         if ((r_state == S_IDLE) && bus.i_start)  r_burst_cnt <= bus.i_burst_len;
         else if (w_rise && (r_burst_cnt != '0)) r_burst_cnt <= r_burst_cnt - WIDTH'(1);
      end
   end

   assign bus.o_done = r_done;
`else
   assign w_burst_last = 1'b0;
`endif

   assign bus.o_div_ready = r_div_ready;
   assign bus.o_roll_over = r_roll;
   assign bus.o_clk       = r_clk;
   assign bus.o_running   = r_running;
endmodule
